// File: rtl/sum_of_n_inverse.sv
// ============================================================================
//  Module   : sum_of_n_inverse
//  Purpose  : Iterative triangular-root finder: largest N<=15 with
//             N(N+1)/2 <= S, plus remainder, one subtraction per clock.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sum_of_n_inverse (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] S,
    output logic [3:0] N,
    output logic [7:0] rem,
    output logic       exact,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] K_LAST = 5'd15;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [4:0] k_q, k_d;
    logic [3:0] n_q, n_d;
    logic [3:0] N_q, N_d;
    logic [7:0] rem_q, rem_d;
    logic       exact_q, exact_d;
    logic       ovf_q, ovf_d;
    logic       can_sub;

    // The compare guards the subtraction, so acc never wraps below zero.
    assign can_sub = (acc_q >= {3'b000, k_q}) && (k_q <= K_LAST);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        n_d     = n_q;
        N_d     = N_q;
        rem_d   = rem_q;
        exact_d = exact_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = S;
                    k_d     = 5'd1;
                    n_d     = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (can_sub) begin
                    acc_d = acc_q - {3'b000, k_q};
                    n_d   = k_q[3:0];
                    k_d   = k_q + 5'd1;
                end else begin
                    N_d     = n_q;
                    rem_d   = acc_q;
                    exact_d = (acc_q == 8'd0);
                    ovf_d   = (n_q == 4'd15) && (acc_q >= 8'd16);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 8'd0;
            k_q     <= 5'd0;
            n_q     <= 4'd0;
            N_q     <= 4'd0;
            rem_q   <= 8'd0;
            exact_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            n_q     <= n_d;
            N_q     <= N_d;
            rem_q   <= rem_d;
            exact_q <= exact_d;
            ovf_q   <= ovf_d;
        end
    end

    assign N     = N_q;
    assign rem   = rem_q;
    assign exact = exact_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sum_of_n_inverse.sv
// ============================================================================
//  Module   : tb_sum_of_n_inverse
//  Purpose  : Directed self-checking bench for sum_of_n_inverse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sum_of_n_inverse;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] S;
    logic [3:0] N;
    logic [7:0] rem;
    logic       exact;
    logic       ovf;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    sum_of_n_inverse dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .S     (S),
        .N     (N),
        .rem   (rem),
        .exact (exact),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one operation and check latency, busy length, results and hold.
    // With inject set, a stray start with S=7 is pushed in mid-RUN.
    task automatic run_op(input string tag, input logic [7:0] s,
                          input int en, input int er, input int ex,
                          input int eo, input int elat, input bit inject);
        int lat;
        int busycnt;
        bit got;
        @(negedge clk);
        S     = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat     = 0;
        busycnt = 0;
        got     = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 3) begin
                S     = 8'd7;
                start = 1'b1;
            end
            if (inject && lat == 4) start = 1'b0;
            if (done) got = 1'b1;
            else if (busy) busycnt++;
        end
        check({tag, ".done_seen"}, int'(got), 1);
        check({tag, ".latency"}, lat - 1, elat);
        check({tag, ".busy_cycles"}, busycnt, elat);
        check({tag, ".busy_in_done"}, int'(busy), 0);
        check({tag, ".N"}, int'(N), en);
        check({tag, ".rem"}, int'(rem), er);
        check({tag, ".exact"}, int'(exact), ex);
        check({tag, ".ovf"}, int'(ovf), eo);
        @(negedge clk);
        check({tag, ".done_pulse_end"}, int'(done), 0);
        check({tag, ".N_hold"}, int'(N), en);
        check({tag, ".rem_hold"}, int'(rem), er);
    endtask

    initial begin
        int dcnt;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        S        = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.N", int'(N), 0);
        check("reset.rem", int'(rem), 0);
        check("reset.exact", int'(exact), 0);
        check("reset.ovf", int'(ovf), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);

        // Reset and start together: reset must win.
        S     = 8'd45;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_vs_start.busy", int'(busy), 0);

        run_op("s0",   8'd0,   0,  0, 1, 0, 1,  1'b0);
        run_op("s45",  8'd45,  9,  0, 1, 0, 10, 1'b0);
        run_op("s50",  8'd50,  9,  5, 0, 0, 10, 1'b0);
        run_op("s120", 8'd120, 15, 0, 1, 0, 16, 1'b0);
        run_op("s200", 8'd200, 15, 80, 0, 1, 16, 1'b0);
        run_op("s45_ign", 8'd45, 9, 0, 1, 0, 10, 1'b1);
        run_op("s7",   8'd7,   3,  1, 0, 0, 4,  1'b0);

        // Reset in the middle of RUN drops the operation.
        @(negedge clk);
        S     = 8'd120;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst.busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst.busy", int'(busy), 0);
        check("midrst.done", int'(done), 0);
        check("midrst.N", int'(N), 0);
        check("midrst.rem", int'(rem), 0);
        check("midrst.exact", int'(exact), 0);
        check("midrst.ovf", int'(ovf), 0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("midrst.no_activity", dcnt, 0);

        run_op("s3", 8'd3, 2, 0, 1, 0, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
